l2_responder: RTL

L2_RESPONDER -- requirements
Module: l2_responder

---
 rtl/l2_responder.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/l2_responder.sv
// l2_responder: responder end of the cache-to-L2 request interface.
// The backing store is MEM_SIZE/4 words of XLEN bits. Each accepted request
// waits LATENCY cycles, then runs once. After that the block gives a one-cycle
// fulfilled pulse and spends one cycle in IDLE before it can accept again.
//
// Ports
//   clk               single clock, rising edge
//   reset             asynchronous active-low reset
//   l2_req_address    byte address; word index = address[log2(MEM_SIZE)-1:2]
//   l2_req_type       LOAD / STORE / other (other = no-op, still fulfilled)
//   l2_req_valid      request present; sampled only in IDLE
//   l2_word_to_store  store data, latched at accept
//   l2_fetched_word   data from the most recent completed LOAD
//   l2_req_fulfilled  one-cycle completion pulse (state == RESPOND)
//   busy              high while in BUSY
//   o_dbg_state       current FSM state, for checkers
//
// Handshake: a request is accepted on a rising edge where the FSM is in IDLE
// and l2_req_valid=1. After that, all request inputs are ignored until the FSM
// is back in IDLE. Completion is the l2_req_fulfilled pulse. There is no
// ready signal. Requesters must wait for the pulse.

package torrence_types;
    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        STORE = 2'd1,
        FLUSH = 2'd2,
        NOP   = 2'd3
    } memory_operation_e;
endpackage

module l2_responder
    import torrence_types::*;
#(
    parameter int XLEN     = 32,
    parameter int MEM_SIZE = 4096,
    parameter int LATENCY  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   l2_req_address,
    input  memory_operation_e l2_req_type,
    input  logic              l2_req_valid,
    input  logic [XLEN-1:0]   l2_word_to_store,
    output logic [XLEN-1:0]   l2_fetched_word,
    output logic              l2_req_fulfilled,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);

    localparam int AW    = $clog2(MEM_SIZE);
    localparam int IDX_W = AW - 2;
    localparam int DEPTH = MEM_SIZE / 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RESPOND = 2'd2
    } state_e;

    state_e             r_state;
    state_e             w_next_state;
    logic [3:0]         r_count;
    logic [IDX_W-1:0]   r_idx;
    memory_operation_e  r_type;
    logic [XLEN-1:0]    r_store_word;
    logic [XLEN-1:0]    r_fetched;
    logic [XLEN-1:0]    r_mem [DEPTH];

    logic               w_accept;
    logic               w_do_op;
    logic [IDX_W-1:0]   w_req_idx;
    logic               w_unused_addr;

    assign w_req_idx = l2_req_address[AW-1:2];
    // Byte-offset and above-range address bits are intentionally dropped.
    // That drop is what gives modulo-MEM_SIZE wrap.
    assign w_unused_addr = ^{l2_req_address[XLEN-1:AW], l2_req_address[1:0]};

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_do_op      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (l2_req_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_count == 4'd0) begin
                    w_do_op      = 1'b1;
                    w_next_state = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                // A valid that is still high here is deliberately not taken.
                // The next accept can only happen after one cycle in IDLE.
                w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_count      <= 4'd0;
            r_idx        <= '0;
            r_type       <= LOAD;
            r_store_word <= '0;
            r_fetched    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_idx        <= w_req_idx;
                r_type       <= l2_req_type;
                r_store_word <= l2_word_to_store;
                r_count      <= 4'(LATENCY - 1);
            end else if (r_state == ST_BUSY && r_count != 4'd0) begin
                r_count <= r_count - 4'd1;
            end
            // The write lands as the FSM enters RESPOND. A following load
            // therefore always sees the stored data.
            if (w_do_op) begin
                if (r_type == LOAD) begin
                    r_fetched <= r_mem[r_idx];
                end else if (r_type == STORE) begin
                    r_mem[r_idx] <= r_store_word;
                end
            end
        end
    end

    assign l2_fetched_word  = r_fetched;
    assign l2_req_fulfilled = (r_state == ST_RESPOND);
    assign busy             = (r_state == ST_BUSY);
    assign o_dbg_state      = r_state;

endmodule
